// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sharing one load-enabled register among N requesters.
// Each grant yields a registered one-cycle load pulse plus ack, then GAP forced idle cycles.
module reg_load_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 4,
    parameter int unsigned GAP = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         ack,
    output logic [W-1:0]         reg_in,
    output logic                 reg_control,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy
);

    localparam int unsigned IW = $clog2(N);
    localparam logic [3:0] GapInit = 4'(GAP);

    typedef enum logic [1:0] {StIdle, StLoad, StGap} state_e;

    state_e         r_state_q, r_state_d;
    logic [IW-1:0]  r_ptr_q, r_ptr_d;
    logic [3:0]     r_cnt_q, r_cnt_d;
    logic [N-1:0]   r_ack_q, r_ack_d;
    logic [W-1:0]   r_reg_in_q, r_reg_in_d;
    logic           r_ctrl_q, r_ctrl_d;
    logic [IW-1:0]  r_gid_q, r_gid_d;
    logic           r_busy_q, r_busy_d;

    logic [W-1:0]   w_data [N];
    logic           w_found;
    logic [IW-1:0]  w_win;
    logic [IW-1:0]  w_idx;

    for (genvar gi = 0; gi < N; gi++) begin : g_data
        assign w_data[gi] = req_data[gi*W +: W];
    end

    // First set request at or after ptr, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = IW'((32'(r_ptr_q) + i) % N);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        r_state_d  = r_state_q;
        r_ptr_d    = r_ptr_q;
        r_cnt_d    = r_cnt_q;
        r_ack_d    = '0;
        r_ctrl_d   = 1'b0;
        r_reg_in_d = r_reg_in_q;
        r_gid_d    = r_gid_q;
        unique case (r_state_q)
            StIdle: begin
                if (w_found) begin
                    r_reg_in_d     = w_data[w_win];
                    r_gid_d        = w_win;
                    r_ack_d[w_win] = 1'b1;
                    r_ctrl_d       = 1'b1;
                    r_state_d      = StLoad;
                end
            end
            StLoad: begin
                r_ptr_d = (r_gid_q == IW'(N - 1)) ? '0 : r_gid_q + 1'b1;
                if (GAP == 0) begin
                    r_state_d = StIdle;
                end else begin
                    r_cnt_d   = GapInit;
                    r_state_d = StGap;
                end
            end
            StGap: begin
                if (r_cnt_q <= 4'd1) begin
                    r_state_d = StIdle;
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            default: r_state_d = StIdle;
        endcase
        r_busy_d = (r_state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= StIdle;
            r_ptr_q    <= '0;
            r_cnt_q    <= '0;
            r_ack_q    <= '0;
            r_reg_in_q <= '0;
            r_ctrl_q   <= 1'b0;
            r_gid_q    <= '0;
            r_busy_q   <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            r_ptr_q    <= r_ptr_d;
            r_cnt_q    <= r_cnt_d;
            r_ack_q    <= r_ack_d;
            r_reg_in_q <= r_reg_in_d;
            r_ctrl_q   <= r_ctrl_d;
            r_gid_q    <= r_gid_d;
            r_busy_q   <= r_busy_d;
        end
    end

    assign ack         = r_ack_q;
    assign reg_in      = r_reg_in_q;
    assign reg_control = r_ctrl_q;
    assign grant_id    = r_gid_q;
    assign busy        = r_busy_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Bench for reg_load_arbiter: a schedule-based reference model for GAP=1 plus a GAP=0 instance
// checked against hand-derived pulse patterns.
module tb_reg_load_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int GAP = 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   ack;
    logic [W-1:0]   reg_in;
    logic           reg_control;
    logic [1:0]     grant_id;
    logic           busy;

    logic [N-1:0]   req_z = '0;
    logic [N*W-1:0] data_z = '0;
    logic [N-1:0]   ack_z;
    logic [W-1:0]   reg_in_z;
    logic           ctrl_z;
    logic [1:0]     gid_z;
    logic           busy_z;

    always #5 clk = ~clk;

    reg_load_arbiter #(.N(N), .W(W), .GAP(GAP)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
        .reg_in(reg_in), .reg_control(reg_control), .grant_id(grant_id), .busy(busy)
    );

    reg_load_arbiter #(.N(N), .W(W), .GAP(0)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .req(req_z), .req_data(data_z), .ack(ack_z),
        .reg_in(reg_in_z), .reg_control(ctrl_z), .grant_id(gid_z), .busy(busy_z)
    );

    // Shared register fed by the arbiter.
    logic [W-1:0] shadow;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow <= '0;
        else if (reg_control) shadow <= reg_in;
    end

    int checks = 0;
    int failures = 0;

    // Reference model: the arbiter may sample at edge m_next_ok or later; a grant at edge e
    // gives a pulse after e, busy through edge e+GAP, next sample at e+2+GAP.
    int           edge_n = 0;
    int           m_next_ok = 0;
    int           m_busy_until = -1;
    int           m_ptr = 0;
    logic [N-1:0] e_ack = '0;
    logic         e_ctrl = 1'b0;
    logic [W-1:0] e_reg_in = '0;
    logic [1:0]   e_gid = '0;
    logic         e_busy = 1'b0;

    wire [11:0] w_obs = {ack, reg_control, reg_in, grant_id, busy};
    wire [11:0] w_exp = {e_ack, e_ctrl, e_reg_in, e_gid, e_busy};

    task automatic model_reset();
        m_ptr = 0;
        m_next_ok = edge_n;
        m_busy_until = edge_n;
        e_ack = '0;
        e_ctrl = 1'b0;
        e_reg_in = '0;
        e_gid = '0;
        e_busy = 1'b0;
    endtask

    task automatic tick();
        int g;
        int idx;
        logic [N-1:0] r;
        @(posedge clk);
        r = req;
        edge_n++;
        e_ack = '0;
        e_ctrl = 1'b0;
        if (edge_n >= m_next_ok && r != '0) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && ((r >> idx) & 1) != 0) g = idx;
            end
            e_ack = N'(1) << g;
            e_ctrl = 1'b1;
            e_reg_in = W'(req_data >> (g * W));
            e_gid = 2'(g);
            m_ptr = (g + 1) % N;
            m_next_ok = edge_n + 2 + GAP;
            m_busy_until = edge_n + GAP;
        end
        e_busy = (edge_n <= m_busy_until);
        @(negedge clk);
    endtask

    function automatic logic [N*W-1:0] put(logic [N*W-1:0] v, int i, logic [W-1:0] d);
        logic [N*W-1:0] m;
        m = (N*W)'({W{1'b1}}) << (i * W);
        return (v & ~m) | ((N*W)'(d) << (i * W));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        req_z = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        if (w_obs !== 12'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=000", w_obs);
        end
        checks++;
        if ({ack_z, ctrl_z, reg_in_z, gid_z, busy_z} !== 12'h0) begin
            failures++;
            $display("FAIL reset_outputs_gap0 got=%h exp=000",
                     {ack_z, ctrl_z, reg_in_z, gid_z, busy_z});
        end
        checks++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        req = 4'b0001;
        req_data = put('0, 0, 4'hA);
        tick();
        if (w_obs !== {4'b0001, 1'b1, 4'hA, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL single_grant got=%h exp=%h", w_obs, {4'b0001, 1'b1, 4'hA, 2'd0, 1'b1});
        end
        checks++;
        req = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (w_obs !== w_exp) begin
                failures++;
                $display("FAIL single_model edge=%0d got=%h exp=%h", edge_n, w_obs, w_exp);
            end
            checks++;
        end
        if (shadow !== 4'hA || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_capture got=%h/%b exp=a/0", shadow, busy);
        end
        checks++;
    endtask

    task automatic test_round_robin();
        logic [W-1:0] seq[$];
        int           at[$];
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) req_data = put(req_data, i, W'(i + 5));
        for (int c = 0; c < 14; c++) begin
            tick();
            if (w_obs !== w_exp) begin
                failures++;
                $display("FAIL rr_model edge=%0d got=%h exp=%h", edge_n, w_obs, w_exp);
            end
            checks++;
            if (reg_control) begin
                seq.push_back(reg_in);
                at.push_back(edge_n);
            end
        end
        if (seq.size() != 5 || seq[0] !== 4'd5 || seq[1] !== 4'd6 || seq[2] !== 4'd7
            || seq[3] !== 4'd8 || seq[4] !== 4'd5) begin
            failures++;
            $display("FAIL rr_sequence got=%p exp=5,6,7,8,5", seq);
        end
        checks++;
        if (at.size() != 5 || at[1] - at[0] != 3 || at[4] - at[3] != 3) begin
            failures++;
            $display("FAIL rr_period got=%p exp=spacing 3", at);
        end
        checks++;
        req = '0;
    endtask

    task automatic test_fairness_wrap();
        int order[$];
        do_reset();
        req = 4'b0100;
        req_data = 16'h4321;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ack[2]) req = '0;
        end
        req = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (w_obs !== w_exp) begin
                failures++;
                $display("FAIL fair_model edge=%0d got=%h exp=%h", edge_n, w_obs, w_exp);
            end
            checks++;
            if (reg_control) order.push_back(int'(grant_id));
        end
        if (order.size() < 2 || order[0] != 0 || order[1] != 2) begin
            failures++;
            $display("FAIL fair_order got=%p exp=0,2", order);
        end
        checks++;
        req = '0;
    endtask

    task automatic test_data_change();
        do_reset();
        req = 4'b0001;
        req_data = put('0, 0, 4'h3);
        tick();
        req_data = put(req_data, 0, 4'hC);
        req = '0;
        tick();
        if (reg_in !== 4'h3 || w_obs !== w_exp) begin
            failures++;
            $display("FAIL data_change got=%h exp=3", reg_in);
        end
        checks++;
        tick();
        if (shadow !== 4'h3) begin
            failures++;
            $display("FAIL data_capture got=%h exp=3", shadow);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [N-1:0] m;
        do_reset();
        req_data = '0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (w_obs !== w_exp) begin
                failures++;
                $display("FAIL random_model edge=%0d got=%h exp=%h", edge_n, w_obs, w_exp);
            end
            checks++;
            for (int i = 0; i < N; i++) begin
                m = N'(1) << i;
                if ((ack & m) != '0) begin
                    if ($urandom_range(1) == 0) req = req & ~m;
                    else req_data = put(req_data, i, W'($urandom));
                end else if ((req & m) == '0 && $urandom_range(2) == 0) begin
                    req = req | m;
                    req_data = put(req_data, i, W'($urandom));
                end
            end
        end
        req = '0;
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        req = 4'b0010;
        req_data = put('0, 1, 4'h7);
        tick();
        #2 rst_n = 1'b0;
        #1;
        if (w_obs !== 12'h0) begin
            failures++;
            $display("FAIL reset_mid_load got=%h exp=000", w_obs);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1000;
        req_data = put('0, 3, 4'h9);
        model_reset();
        tick();
        if (w_obs !== w_exp || ack !== 4'b1000 || grant_id !== 2'd3 || reg_in !== 4'h9) begin
            failures++;
            $display("FAIL reset_regrant got=%h exp=%h", w_obs, w_exp);
        end
        checks++;
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_gap0();
        logic [N-1:0] xa;
        logic         xc;
        logic [W-1:0] xd;
        do_reset();
        req_z = 4'b0011;
        data_z = 16'h0021;
        for (int i = 0; i < 8; i++) begin
            tick();
            xc = (i % 2 == 0);
            xa = (i % 4 == 0) ? 4'b0001 : (i % 4 == 2) ? 4'b0010 : 4'b0000;
            xd = (i % 4 < 2) ? 4'd1 : 4'd2;
            if ({ack_z, ctrl_z, reg_in_z, busy_z} !== {xa, xc, xd, xc}) begin
                failures++;
                $display("FAIL gap0_pulse i=%0d got=%h exp=%h", i,
                         {ack_z, ctrl_z, reg_in_z, busy_z}, {xa, xc, xd, xc});
            end
            checks++;
        end
        req_z = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness_wrap();
        test_data_change();
        test_random();
        test_reset_mid_load();
        test_gap0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
